instr_fetch_dispatch: RTL and testbench

INSTR_FETCH_DISPATCH -- requirements
Module: instr_fetch_dispatch

---
 rtl/instr_fetch_dispatch_if.sv | 30 +++
 rtl/instr_fetch_dispatch.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_dispatch.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_dispatch_if.sv
// Fetch/dispatch bundle: program-memory port, executor handshakes and status flags.
// master = fetch/dispatch unit, slave = memory plus executor FSMs.
interface instr_fetch_dispatch_if;
   logic [15:0] mem_rdata;
   logic        mem_valid;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic        pc_inc;
   logic        exec_done;
   logic [15:0] instr;
   logic        alu_start;
   logic        alui_start;
   logic        load_start;
   logic        store_start;
   logic        halted;
   logic        illegal;
   logic        fetch_err;

   modport master (
      input  mem_rdata, mem_valid, pc_inc, exec_done,
      output mem_req, mem_addr, instr, alu_start, alui_start, load_start, store_start,
             halted, illegal, fetch_err
   );

   modport slave (
      output mem_rdata, mem_valid, pc_inc, exec_done,
      input  mem_req, mem_addr, instr, alu_start, alui_start, load_start, store_start,
             halted, illegal, fetch_err
   );
endinterface

// File: rtl/instr_fetch_dispatch.sv
// Instruction fetch, decode and dispatch to executor FSMs; HALT/TRAP are left only by rst.
// Optional macro FETCH_TIMEOUT_EN traps after 16 consecutive FETCH cycles without mem_valid.
module instr_fetch_dispatch (
   input logic                     clk,
   input logic                     rst,
   instr_fetch_dispatch_if.master  bus
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StHalt,
      StTrap
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [3:0]  start_q, start_d;
   logic        halted_q, halted_d;
   logic        illegal_q, illegal_d;
   logic [3:0]  opcode;
   logic        exec_first;

   assign opcode     = ir_q[15:12];
   // start_q is only ever high in the first EXEC cycle, so it doubles as that marker
   assign exec_first = |start_q;

`ifdef FETCH_TIMEOUT_EN
   logic [3:0] tmo_q, tmo_d;
   logic       fetch_err_q, fetch_err_d;
   logic       timeout;

   always_comb begin
      tmo_d   = '0;
      timeout = 1'b0;
      if (state_q == StFetch && !bus.mem_valid) begin
         tmo_d   = tmo_q + 4'd1;
         timeout = (tmo_q == 4'hF);
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      start_d   = '0;
      halted_d  = halted_q;
      illegal_d = illegal_q;
`ifdef FETCH_TIMEOUT_EN
      fetch_err_d = fetch_err_q;
`endif

      if (bus.pc_inc && (state_q inside {StIdle, StFetch, StDecode, StExec})) begin
         pc_d = pc_q + 8'd1;
      end

      unique case (state_q)
         StIdle: state_d = StFetch;
         StFetch: begin
            if (bus.mem_valid) begin
               ir_d    = bus.mem_rdata;
               state_d = StDecode;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (timeout) begin
               fetch_err_d = 1'b1;
               state_d     = StTrap;
            end
`endif
         end
         StDecode: begin
            if (opcode[3:2] == 2'b00) begin
               start_d[opcode[1:0]] = 1'b1;
               state_d              = StExec;
            end else if (opcode == 4'hF) begin
               halted_d = 1'b1;
               state_d  = StHalt;
            end else begin
               illegal_d = 1'b1;
               state_d   = StTrap;
            end
         end
         StExec: begin
            if (!exec_first && bus.exec_done) begin
               state_d = StFetch;
            end
         end
         StHalt, StTrap: state_d = state_q;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         pc_q      <= '0;
         ir_q      <= '0;
         start_q   <= '0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         start_q   <= start_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_q       <= '0;
         fetch_err_q <= 1'b0;
      end else begin
         tmo_q       <= tmo_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   assign bus.fetch_err = fetch_err_q;
`else
   assign bus.fetch_err = 1'b0;
`endif

   assign bus.mem_req     = (state_q == StFetch);
   assign bus.mem_addr    = pc_q;
   assign bus.instr       = ir_q;
   assign bus.alu_start   = start_q[0];
   assign bus.alui_start  = start_q[1];
   assign bus.load_start  = start_q[2];
   assign bus.store_start = start_q[3];
   assign bus.halted      = halted_q;
   assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_instr_fetch_dispatch.sv
// Scoreboard bench for instr_fetch_dispatch: directed scenarios plus randomized programs.
// Honours FETCH_TIMEOUT_EN the same way as the design.
module tb_instr_fetch_dispatch;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instr_fetch_dispatch_if bus ();

   instr_fetch_dispatch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // kind: 0..3 = start index, 4 = halt, 5 = trap
   typedef struct {
      logic [15:0] w;
      int          kind;
      logic [7:0]  pc;
   } exp_t;

   exp_t       sbq[$];
   int         total = 0;
   int         bad = 0;
   logic [7:0] pc_m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] starts();
      return {bus.store_start, bus.load_start, bus.alui_start, bus.alu_start};
   endfunction

   function automatic int kind_of(input logic [15:0] w);
      if (w[15:12] <= 4'd3) return int'(w[13:12]);
      if (w[15:12] == 4'hF) return 4;
      return 5;
   endfunction

   // Monitor: every start pulse or rising halted/illegal consumes one expectation
   logic [3:0] mon_s;
   int         mon_kind;
   exp_t       mon_e;
   logic       halted_p = 1'b0;
   logic       illegal_p = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         mon_s = starts();
         if (!rst && (mon_s != 4'd0 || (bus.halted && !halted_p) ||
                      (bus.illegal && !illegal_p))) begin
            if (mon_s != 4'd0) chk("start_onehot", $countones(mon_s), 1);
            if (mon_s[0])      mon_kind = 0;
            else if (mon_s[1]) mon_kind = 1;
            else if (mon_s[2]) mon_kind = 2;
            else if (mon_s[3]) mon_kind = 3;
            else if (bus.halted && !halted_p) mon_kind = 4;
            else               mon_kind = 5;
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected: event kind %0d with empty queue", mon_kind);
            end else begin
               mon_e = sbq.pop_front();
               chk("sb_kind", mon_kind, mon_e.kind);
               chk("sb_instr", bus.instr, mon_e.w);
               chk("sb_pc", bus.mem_addr, mon_e.pc);
            end
         end
         halted_p  = bus.halted;
         illegal_p = bus.illegal;
      end
   end

   task automatic do_reset(input bit idle_inc);
      bus.mem_valid = 1'b0;
      bus.pc_inc    = 1'b1;  // must be ignored under reset
      bus.exec_done = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      bus.pc_inc = idle_inc;
      cyc();
      bus.pc_inc = 1'b0;
      pc_m = 8'(idle_inc);
   endtask

   // Drives one fetch (k idle FETCH cycles first) and the DECODE cycle; queues the expectation.
   task automatic fetch_word(input logic [15:0] w, input int k, input bit rnd);
      int          n;
      logic [15:0] incs;
      logic        vinc, dinc;
      logic [7:0]  p;
      exp_t        e;
      n = 0;
      while (bus.mem_req !== 1'b1 && n < 50) begin
         cyc();
         n++;
      end
      if (bus.mem_req !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL fetch_wait: mem_req %b expected 1", bus.mem_req);
         return;
      end
      incs = rnd ? 16'($urandom) : 16'd0;
      vinc = rnd ? 1'($urandom) : 1'b0;
      dinc = rnd ? 1'($urandom) : 1'b0;
      p = pc_m + 8'(vinc) + 8'(dinc);
      for (int i = 0; i < k; i++) p = p + 8'(incs[i]);
      e.w = w;
      e.kind = kind_of(w);
      e.pc = p;
      sbq.push_back(e);
      for (int i = 0; i < k; i++) begin
         bus.mem_valid = 1'b0;
         bus.mem_rdata = 16'($urandom);
         bus.pc_inc    = incs[i];
         bus.exec_done = rnd ? 1'($urandom) : 1'b0;
         cyc();
      end
      bus.mem_valid = 1'b1;
      bus.mem_rdata = w;
      bus.pc_inc    = vinc;
      bus.exec_done = 1'b0;
      cyc();
      chk("ir_load", bus.instr, w);
      bus.mem_valid = 1'b0;
      bus.mem_rdata = 16'($urandom);
      bus.pc_inc    = dinc;
      bus.exec_done = rnd ? 1'($urandom) : 1'b0;
      cyc();
      bus.pc_inc    = 1'b0;
      bus.exec_done = 1'b0;
      pc_m = p;
      chk("ir_hold", bus.instr, w);
   endtask

   // Starts in the first EXEC cycle; m extra busy cycles before exec_done.
   task automatic exec_phase(input int m, input bit rnd);
      bus.pc_inc    = rnd ? 1'($urandom) : 1'b1;
      bus.exec_done = rnd ? 1'($urandom) : 1'b0;  // ignored in the start cycle
      pc_m = pc_m + 8'(bus.pc_inc);
      cyc();
      for (int i = 0; i < m; i++) begin
         bus.pc_inc    = rnd ? 1'($urandom) : 1'b0;
         bus.exec_done = 1'b0;
         pc_m = pc_m + 8'(bus.pc_inc);
         cyc();
      end
      bus.pc_inc    = rnd ? 1'($urandom) : 1'b0;
      bus.exec_done = 1'b1;
      pc_m = pc_m + 8'(bus.pc_inc);
      cyc();
      bus.pc_inc    = 1'b0;
      bus.exec_done = 1'b0;
      chk("exec_ret_req", bus.mem_req, 1);
      chk("exec_ret_pc", bus.mem_addr, pc_m);
   endtask

   task automatic sticky_check(input bit is_halt);
      for (int i = 0; i < 4; i++) begin
         bus.pc_inc    = 1'b1;
         bus.exec_done = 1'($urandom);
         bus.mem_valid = 1'($urandom);
         cyc();
         chk("sticky_req", bus.mem_req, 0);
         chk("sticky_pc", bus.mem_addr, pc_m);
         chk("sticky_flags", {bus.halted, bus.illegal}, is_halt ? 2'b10 : 2'b01);
         chk("sticky_nostart", starts(), 0);
      end
      bus.pc_inc    = 1'b0;
      bus.exec_done = 1'b0;
      bus.mem_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w;
      int          n;
      bus.mem_rdata = '0;
      bus.mem_valid = 1'b0;
      bus.pc_inc    = 1'b0;
      bus.exec_done = 1'b0;

      // reset values
      rst = 1'b1;
      cyc();
      chk("rst_req", bus.mem_req, 0);
      chk("rst_pc", bus.mem_addr, 0);
      chk("rst_instr", bus.instr, 0);
      chk("rst_starts", starts(), 0);
      chk("rst_flags", {bus.halted, bus.illegal, bus.fetch_err}, 0);
      rst = 1'b0;
      chk("idle_req", bus.mem_req, 0);
      cyc();
      chk("fetch_req", bus.mem_req, 1);
      pc_m = 8'd0;

      // valid on third FETCH cycle, ALU-immediate dispatch
      fetch_word(16'h1002, 2, 1'b0);
      chk("alui_start", bus.alui_start, 1);
      chk("alui_pc", bus.mem_addr, 0);
      exec_phase(0, 1'b0);

      // HALT
      fetch_word(16'hF000, 1, 1'b0);
      chk("halted_set", bus.halted, 1);
      sticky_check(1'b1);

      // illegal opcode
      do_reset(1'b0);
      fetch_word(16'h7ABC, 0, 1'b0);
      chk("illegal_set", bus.illegal, 1);
      sticky_check(1'b0);

      // PC wrap over 256 increments inside one long EXEC
      do_reset(1'b0);
      fetch_word(16'h0000, 0, 1'b0);
      for (int i = 1; i <= 256; i++) begin
         bus.pc_inc = 1'b1;
         cyc();
         if (i == 255) chk("pc_ff", bus.mem_addr, 8'hFF);
      end
      chk("pc_wrap", bus.mem_addr, 8'h00);
      bus.pc_inc    = 1'b0;
      bus.exec_done = 1'b1;
      cyc();
      bus.exec_done = 1'b0;
      chk("wrap_ret_req", bus.mem_req, 1);
      pc_m = 8'd0;

      // reset mid-EXEC
      fetch_word(16'h3456, 1, 1'b0);
      bus.pc_inc = 1'b1;
      cyc();
      rst = 1'b1;
      bus.exec_done = 1'b1;
      cyc();
      chk("mid_rst_state", {bus.mem_req, bus.mem_addr, bus.instr, starts(),
                            bus.halted, bus.illegal, bus.fetch_err}, 0);
      rst = 1'b0;
      bus.pc_inc    = 1'b0;
      bus.exec_done = 1'b0;
      chk("mid_rst_idle", bus.mem_req, 0);
      cyc();
      chk("mid_rst_fetch", bus.mem_req, 1);
      pc_m = 8'd0;

      // mem_valid held low
`ifdef FETCH_TIMEOUT_EN
      for (int i = 0; i < 15; i++) cyc();
      chk("tmo_before_req", bus.mem_req, 1);
      chk("tmo_before_err", bus.fetch_err, 0);
      cyc();
      chk("tmo_err", bus.fetch_err, 1);
      chk("tmo_req", bus.mem_req, 0);
      chk("tmo_illegal", bus.illegal, 0);
      bus.pc_inc = 1'b1;
      cyc();
      bus.pc_inc = 1'b0;
      chk("tmo_pc", bus.mem_addr, 0);
`else
      for (int i = 0; i < 100; i++) cyc();
      chk("wait_req", bus.mem_req, 1);
      chk("wait_err", bus.fetch_err, 0);
`endif

      // randomized programs
      for (int r = 0; r < 40; r++) begin
         do_reset(1'($urandom));
         n = 1 + int'($urandom_range(0, 5));
         for (int j = 0; j < n; j++) begin
            w = {4'($urandom_range(0, 3)), 12'($urandom)};
            fetch_word(w, int'($urandom_range(0, 5)), 1'b1);
            exec_phase(int'($urandom_range(0, 3)), 1'b1);
         end
         case ($urandom_range(0, 2))
            1: begin
               fetch_word({4'hF, 12'($urandom)}, int'($urandom_range(0, 5)), 1'b1);
               sticky_check(1'b1);
            end
            2: begin
               fetch_word({4'($urandom_range(4, 14)), 12'($urandom)},
                          int'($urandom_range(0, 5)), 1'b1);
               sticky_check(1'b0);
            end
            default: ;
         endcase
      end

      cyc();
      cyc();
      chk("sb_drained", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
